decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have parameter NLANES, default 2, meaning instructions decoded per bundle (1..4).
REQ-002 The module SHALL have parameter DEPTH, default 2, meaning output buffer entries (power of two, >=2).
REQ-003 The module SHALL have parameter CNT_W, default 32, meaning width of the decoded-instruction counter.
REQ-004 The module SHALL have port clk_i  input  1  the single clock, rising edge.
REQ-005 The module SHALL have port rstn_i  input  1  reset, asynchronous and active-low.
REQ-006 The module SHALL have port flush_i  input  1  discards all buffered and incoming bundles.
REQ-007 The module SHALL have port valid_i  input  1  an input bundle is present.
REQ-008 The module SHALL have port fetch_i  input  NLANES x fetch_out_t  fetched instructions, lane 0 oldest.
REQ-009 The module SHALL have port lane_mask_i  input  NLANES  per-lane instruction present.
REQ-010 The module SHALL have port ready_o  output  1  bundle accepted this cycle when high with valid_i.
REQ-011 The module SHALL have port valid_o  output  1  the output bundle is valid.
REQ-012 The module SHALL have port ready_i  input  1  the consumer takes the bundle.
REQ-013 The module SHALL have port instr_o  output  NLANES x instr_entry_t  decoded instructions.
REQ-014 The module SHALL have port lane_mask_o  output  NLANES  per-lane valid after truncation.
REQ-015 The module SHALL have port decoded_cnt_o  output  CNT_W  count of lanes delivered.

Function
REQ-016 Each lane SHALL decode full RV64I (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU, ALU_I, ALU_W, ALU_I_W, FENCE, SYSTEM) into unit, alu_op, use_imm, use_pc, regfile_we, change_pc_ena and result=sign-extended immediate.
REQ-017 ALU register ops SHALL map F3_SLL->ALU_SLL, F3_SLT->ALU_SLT, F3_SLTU->ALU_SLTU; SUB/SRA SHALL require func7=F7_SRAI_SUB_SRA, others F7_NORMAL.
REQ-018 RV64 shift-immediates SHALL use a 6-bit shamt and check inst[31:26]; W shift-immediates SHALL treat inst[25]=1 as illegal.
REQ-019 Unknown opcode, func3 or func7 combination SHALL set ex.valid=1, ex.cause=ILLEGAL_INSTR (2), ex.origin=instruction word.
REQ-020 pc_inst[1:0]!=0 SHALL set ex.cause=INSTR_ADDR_MISALIGNED (0), taking priority over illegal.
REQ-021 Any lane carrying an exception, or with change_pc_ena=1, SHALL clear lane_mask for all younger lanes; the excepting lane stays valid.
REQ-022 Bundles with lane_mask_i all-zero SHALL be accepted and dropped (no buffer write).
REQ-023 ready_o SHALL equal (count < DEPTH) from registered state; a pop in the same cycle does not raise it.
REQ-024 Push (valid_i & ready_o) SHALL write the decoded bundle at the tail; latency input-to-valid_o is exactly one cycle.
REQ-025 valid_o SHALL equal (count != 0); instr_o/lane_mask_o SHALL present the head entry and hold stable while valid_o & !ready_i.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 flush_i SHALL zero count and pointers next cycle and suppress any same-cycle push and counter update.
REQ-028 decoded_cnt_o SHALL add popcount(lane_mask_o) on each pop, wrapping at 2^CNT_W.

Reset
REQ-029 On rstn_i low, count, pointers and decoded_cnt_o SHALL clear immediately; valid_o=0, ready_o=1, lane_mask_o=0, instr_o=0.
REQ-030 Reset assertion mid-transfer SHALL discard all buffered bundles; no partial bundle is delivered after release.

Structure
REQ-031 exception cause codes and instr_entry_t ex field SHALL live in drac_pkg; opcode/func3/func7 constants in riscv_pkg.
REQ-032 Per-lane decode SHALL be a combinational sub-module decode_lane, instantiated NLANES times with a generate loop.
REQ-033 Buffer storage SHALL be flop-based, no memory macro.

Verification
REQ-034 ADDI x1,x0,5 (0x00500093) lane 0, mask 01 -> next cycle valid_o=1, alu_op=ALU_ADD, use_imm=1, rd=1, result=5.
REQ-035 Lane0 0x00000000, lane1 0x00500093, mask 11 -> lane0 ex.cause=2, lane_mask_o=01, decoded_cnt_o +1 on pop.
REQ-036 ready_i=0, push three bundles back-to-back (DEPTH=2) -> ready_o=0 after second, third held; ready_i=1 then drains in order.
REQ-037 SRAI with inst[31:26]=0x11 -> ex.cause=2; SLLI shamt 63 (0x03F09093) -> legal ALU_SLL.
REQ-038 flush_i with count=2 and valid_i=1 -> next cycle valid_o=0, count=0, counter unchanged.
REQ-039 rstn_i low with count=1 -> valid_o=0 same cycle, decoded_cnt_o=0; preset counter to 2^32-1, pop mask 11 -> wraps to 1.

Source files
------------

// File: rtl/drac_pkg.sv
// Core-wide types: fetch bundle lanes, decoded instruction entries and exceptions.
package drac_pkg;

  typedef enum logic [3:0] {
    INSTR_ADDR_MISALIGNED = 4'd0,
    ILLEGAL_INSTR         = 4'd2
  } exception_cause_t;

  typedef struct packed {
    logic             valid;
    exception_cause_t cause;
    logic [63:0]      origin;
  } exception_t;

  typedef enum logic [1:0] {
    UNIT_ALU,
    UNIT_BRANCH,
    UNIT_MEM,
    UNIT_SYSTEM
  } functional_unit_t;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU, ALU_JAL, ALU_JALR
  } alu_op_t;

  typedef struct packed {
    logic [63:0] pc_inst;
    logic [31:0] inst;
  } fetch_out_t;

  typedef struct packed {
    logic [63:0]      pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    functional_unit_t unit;
    alu_op_t          alu_op;
    logic             use_imm;
    logic             use_pc;
    logic             regfile_we;
    logic             change_pc_ena;
    logic [63:0]      result;
    exception_t       ex;
  } instr_entry_t;

endpackage

// File: rtl/riscv_pkg.sv
// RISC-V base ISA encoding constants shared by the decode logic.
package riscv_pkg;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_ALU_I   = 7'b0010011;
  localparam logic [6:0] OP_ALU     = 7'b0110011;
  localparam logic [6:0] OP_ALU_I_W = 7'b0011011;
  localparam logic [6:0] OP_ALU_W   = 7'b0111011;
  localparam logic [6:0] OP_FENCE   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [2:0] F3_BEQ     = 3'd0;
  localparam logic [2:0] F3_BNE     = 3'd1;
  localparam logic [2:0] F3_BLT     = 3'd4;
  localparam logic [2:0] F3_BGE     = 3'd5;
  localparam logic [2:0] F3_BLTU    = 3'd6;
  localparam logic [2:0] F3_BGEU    = 3'd7;

  localparam logic [2:0] F3_LWU     = 3'd6;
  localparam logic [2:0] F3_SD      = 3'd3;
  localparam logic [2:0] F3_CSRRWI  = 3'd5;
  localparam logic [2:0] F3_PRIV    = 3'd0;
  localparam logic [2:0] F3_FENCE_I = 3'd1;

  localparam logic [6:0] F7_NORMAL       = 7'b0000000;
  localparam logic [6:0] F7_SRAI_SUB_SRA = 7'b0100000;

endpackage

// File: rtl/decode_lane.sv
// Combinational RV64I decoder for a single fetch lane.
module decode_lane
  import drac_pkg::*;
  import riscv_pkg::*;
(
  input  fetch_out_t   fetch_i,
  output instr_entry_t instr_o
);

  logic [31:0]  inst;
  logic [6:0]   opcode;
  logic [2:0]   func3;
  logic [6:0]   func7;
  logic [63:0]  imm_i, imm_s, imm_b, imm_u, imm_j;
  logic         illegal;
  instr_entry_t d;

  assign inst   = fetch_i.inst;
  assign opcode = inst[6:0];
  assign func3  = inst[14:12];
  assign func7  = inst[31:25];
  assign imm_i  = {{52{inst[31]}}, inst[31:20]};
  assign imm_s  = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign imm_j  = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    d          = '0;
    illegal    = 1'b0;
    d.pc       = fetch_i.pc_inst;
    d.rs1      = inst[19:15];
    d.rs2      = inst[24:20];
    d.rd       = inst[11:7];
    d.funct3   = func3;
    d.unit     = UNIT_ALU;
    d.alu_op   = ALU_ADD;
    case (opcode)
      OP_LUI: begin
        d.use_imm = 1'b1; d.regfile_we = 1'b1; d.result = imm_u; d.rs1 = '0;
      end
      OP_AUIPC: begin
        d.use_imm = 1'b1; d.use_pc = 1'b1; d.regfile_we = 1'b1; d.result = imm_u;
      end
      OP_JAL: begin
        d.unit = UNIT_BRANCH; d.alu_op = ALU_JAL; d.use_imm = 1'b1; d.use_pc = 1'b1;
        d.regfile_we = 1'b1; d.change_pc_ena = 1'b1; d.result = imm_j;
      end
      OP_JALR: begin
        d.unit = UNIT_BRANCH; d.alu_op = ALU_JALR; d.use_imm = 1'b1;
        d.regfile_we = 1'b1; d.change_pc_ena = 1'b1; d.result = imm_i;
        illegal = (func3 != 3'd0);
      end
      OP_BRANCH: begin
        d.unit = UNIT_BRANCH; d.result = imm_b;
        case (func3)
          F3_BEQ:  d.alu_op = ALU_BEQ;
          F3_BNE:  d.alu_op = ALU_BNE;
          F3_BLT:  d.alu_op = ALU_BLT;
          F3_BGE:  d.alu_op = ALU_BGE;
          F3_BLTU: d.alu_op = ALU_BLTU;
          F3_BGEU: d.alu_op = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        d.unit = UNIT_MEM; d.use_imm = 1'b1; d.regfile_we = 1'b1; d.result = imm_i;
        illegal = (func3 > F3_LWU);
      end
      OP_STORE: begin
        d.unit = UNIT_MEM; d.use_imm = 1'b1; d.result = imm_s;
        illegal = (func3 > F3_SD);
      end
      OP_ALU_I: begin
        d.use_imm = 1'b1; d.regfile_we = 1'b1; d.result = imm_i;
        case (func3)
          F3_ADD_SUB: d.alu_op = ALU_ADD;
          F3_SLT:     d.alu_op = ALU_SLT;
          F3_SLTU:    d.alu_op = ALU_SLTU;
          F3_XOR:     d.alu_op = ALU_XOR;
          F3_OR:      d.alu_op = ALU_OR;
          F3_AND:     d.alu_op = ALU_AND;
          F3_SLL: begin
            d.alu_op = ALU_SLL; d.result = {58'b0, inst[25:20]};
            illegal  = (inst[31:26] != 6'b000000);
          end
          default: begin
            d.result = {58'b0, inst[25:20]};
            if (inst[31:26] == 6'b000000)      d.alu_op = ALU_SRL;
            else if (inst[31:26] == 6'b010000) d.alu_op = ALU_SRA;
            else                               illegal  = 1'b1;
          end
        endcase
      end
      OP_ALU: begin
        d.regfile_we = 1'b1;
        if (func7 == F7_NORMAL) begin
          case (func3)
            F3_ADD_SUB: d.alu_op = ALU_ADD;
            F3_SLL:     d.alu_op = ALU_SLL;
            F3_SLT:     d.alu_op = ALU_SLT;
            F3_SLTU:    d.alu_op = ALU_SLTU;
            F3_XOR:     d.alu_op = ALU_XOR;
            F3_SRL_SRA: d.alu_op = ALU_SRL;
            F3_OR:      d.alu_op = ALU_OR;
            default:    d.alu_op = ALU_AND;
          endcase
        end else if (func7 == F7_SRAI_SUB_SRA && func3 == F3_ADD_SUB) begin
          d.alu_op = ALU_SUB;
        end else if (func7 == F7_SRAI_SUB_SRA && func3 == F3_SRL_SRA) begin
          d.alu_op = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ALU_I_W: begin
        d.use_imm = 1'b1; d.regfile_we = 1'b1; d.result = imm_i;
        // W shifts only have a 5-bit shamt, so inst[25] must be zero
        if (func3 == F3_ADD_SUB) begin
          d.alu_op = ALU_ADDW;
        end else if (func3 == F3_SLL && func7 == F7_NORMAL) begin
          d.alu_op = ALU_SLLW; d.result = {59'b0, inst[24:20]};
        end else if (func3 == F3_SRL_SRA && func7 == F7_NORMAL) begin
          d.alu_op = ALU_SRLW; d.result = {59'b0, inst[24:20]};
        end else if (func3 == F3_SRL_SRA && func7 == F7_SRAI_SUB_SRA) begin
          d.alu_op = ALU_SRAW; d.result = {59'b0, inst[24:20]};
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ALU_W: begin
        d.regfile_we = 1'b1;
        if (func3 == F3_ADD_SUB && func7 == F7_NORMAL)            d.alu_op = ALU_ADDW;
        else if (func3 == F3_ADD_SUB && func7 == F7_SRAI_SUB_SRA) d.alu_op = ALU_SUBW;
        else if (func3 == F3_SLL && func7 == F7_NORMAL)           d.alu_op = ALU_SLLW;
        else if (func3 == F3_SRL_SRA && func7 == F7_NORMAL)       d.alu_op = ALU_SRLW;
        else if (func3 == F3_SRL_SRA && func7 == F7_SRAI_SUB_SRA) d.alu_op = ALU_SRAW;
        else                                                      illegal  = 1'b1;
      end
      OP_FENCE: begin
        d.unit  = UNIT_SYSTEM;
        illegal = (func3 != F3_PRIV) && (func3 != F3_FENCE_I);
      end
      OP_SYSTEM: begin
        d.unit          = UNIT_SYSTEM;
        d.result        = imm_i;
        d.use_imm       = func3[2];
        d.regfile_we    = (func3 != F3_PRIV);
        d.change_pc_ena = (func3 == F3_PRIV);
        illegal         = (func3 == 3'd4);
      end
      default: illegal = 1'b1;
    endcase

    if (fetch_i.pc_inst[1:0] != 2'b00) begin
      d.ex.valid  = 1'b1;
      d.ex.cause  = INSTR_ADDR_MISALIGNED;
      d.ex.origin = fetch_i.pc_inst;
    end else if (illegal) begin
      d.ex.valid  = 1'b1;
      d.ex.cause  = ILLEGAL_INSTR;
      d.ex.origin = {32'b0, inst};
    end
    if (d.ex.valid) begin
      d.regfile_we    = 1'b0;
      d.change_pc_ena = 1'b0;
    end
  end

  assign instr_o = d;

endmodule

// File: rtl/decode_stage.sv
// Multi-lane decode stage: per-lane decode, younger-lane truncation and a small
// flop-based output buffer with a delivered-lane counter.
module decode_stage
  import drac_pkg::*;
#(
  parameter int unsigned NLANES = 2,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  fetch_out_t   [NLANES-1:0] fetch_i,
  input  logic         [NLANES-1:0] lane_mask_i,
  output logic                      ready_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output instr_entry_t [NLANES-1:0] instr_o,
  output logic         [NLANES-1:0] lane_mask_o,
  output logic         [CNT_W-1:0]  decoded_cnt_o
);

  localparam int unsigned    PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  instr_entry_t [NLANES-1:0] dec;
  logic         [NLANES-1:0] dec_mask;

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    decode_lane u_decode_lane (
      .fetch_i (fetch_i[g]),
      .instr_o (dec[g])
    );
  end

  // A lane that redirects or traps kills every younger lane behind it
  always_comb begin : truncate
    logic kill;
    kill     = 1'b0;
    dec_mask = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      dec_mask[i] = lane_mask_i[i] & ~kill;
      if (dec_mask[i] && (dec[i].ex.valid || dec[i].change_pc_ena)) kill = 1'b1;
    end
  end

  instr_entry_t [NLANES-1:0] buf_q  [DEPTH];
  instr_entry_t [NLANES-1:0] buf_d  [DEPTH];
  logic         [NLANES-1:0] mask_q [DEPTH];
  logic         [NLANES-1:0] mask_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pop_lanes;
  logic             push, pop;

  assign ready_o       = (count_q < DEPTH_C);
  assign valid_o       = (count_q != '0);
  assign instr_o       = valid_o ? buf_q[rd_ptr_q]  : '0;
  assign lane_mask_o   = valid_o ? mask_q[rd_ptr_q] : '0;
  assign decoded_cnt_o = cnt_q;

  always_comb begin
    push      = valid_i & ready_o & ~flush_i & (|lane_mask_i);
    pop       = valid_o & ready_i & ~flush_i;
    pop_lanes = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      pop_lanes = pop_lanes + CNT_W'(lane_mask_o[i]);
    end
    buf_d    = buf_q;
    mask_d   = mask_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        buf_d[wr_ptr_q]  = dec;
        mask_d[wr_ptr_q] = dec_mask;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d    = cnt_q + pop_lanes;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      buf_q    <= '{default: '0};
      mask_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      mask_q   <= mask_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: single-bundle decode vectors plus
// backpressure, drop, flush, reset and counter-wrap sequences.
module tb_decode_stage;
  import drac_pkg::*;

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [63:0] pc0;
    logic [1:0]  mi;
    logic [1:0]  mo;
    logic        ex0;
    logic [3:0]  cause0;
    logic        chk;
    alu_op_t     alu0;
    logic        imm0;
    logic [4:0]  rd0;
    logic [63:0] res0;
    alu_op_t     alu1;
  } vec_t;

  logic clk = 1'b0;
  logic rstn, flush, valid, ready_in;
  fetch_out_t   [1:0] fetch;
  logic         [1:0] mask_in;
  logic               ready, vout;
  instr_entry_t [1:0] instr;
  logic         [1:0] mask_out;
  logic        [31:0] cnt;
  logic               ready_w, vout_w;
  instr_entry_t [1:0] instr_w;
  logic         [1:0] mask_w;
  logic         [1:0] cnt_w;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] cnt_exp;
  vec_t vecs [13];

  always #5 clk = ~clk;

  decode_stage #(.NLANES(2), .DEPTH(2), .CNT_W(32)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .valid_i(valid),
    .fetch_i(fetch), .lane_mask_i(mask_in), .ready_o(ready), .valid_o(vout),
    .ready_i(ready_in), .instr_o(instr), .lane_mask_o(mask_out), .decoded_cnt_o(cnt)
  );

  decode_stage #(.NLANES(2), .DEPTH(2), .CNT_W(2)) dut_wrap (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .valid_i(valid),
    .fetch_i(fetch), .lane_mask_i(mask_in), .ready_o(ready_w), .valid_o(vout_w),
    .ready_i(ready_in), .instr_o(instr_w), .lane_mask_o(mask_w), .decoded_cnt_o(cnt_w)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [31:0] i0, input logic [31:0] i1,
                            input logic [63:0] pc0, input logic [1:0] m);
    fetch[0].inst    = i0;
    fetch[0].pc_inst = pc0;
    fetch[1].inst    = i1;
    fetch[1].pc_inst = pc0 + 64'd4;
    mask_in          = m;
  endtask

  function automatic logic [31:0] pop2(input logic [1:0] m);
    return 32'(m[0]) + 32'(m[1]);
  endfunction

  task automatic push_pop(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] m);
    set_bundle(i0, i1, 64'h1000, m);
    valid    = 1'b1;
    ready_in = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    cnt_exp = cnt_exp + pop2(m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h00500093, 32'h00000013, 64'h1000, 2'b01, 2'b01, 1'b0, 4'd0, 1'b1, ALU_ADD,  1'b1, 5'd1, 64'd5,  ALU_ADD};
    vecs[1]  = '{32'h00000000, 32'h00500093, 64'h1000, 2'b11, 2'b01, 1'b1, 4'd2, 1'b0, ALU_ADD,  1'b0, 5'd0, 64'd0,  ALU_ADD};
    vecs[2]  = '{32'h03F09093, 32'h00000013, 64'h1000, 2'b01, 2'b01, 1'b0, 4'd0, 1'b1, ALU_SLL,  1'b1, 5'd1, 64'd63, ALU_ADD};
    vecs[3]  = '{32'h4410D093, 32'h00000013, 64'h1000, 2'b01, 2'b01, 1'b1, 4'd2, 1'b0, ALU_ADD,  1'b0, 5'd0, 64'd0,  ALU_ADD};
    vecs[4]  = '{32'h4210D093, 32'h00000013, 64'h1000, 2'b01, 2'b01, 1'b0, 4'd0, 1'b1, ALU_SRA,  1'b1, 5'd1, 64'd33, ALU_ADD};
    vecs[5]  = '{32'h00500093, 32'h00500093, 64'h1002, 2'b11, 2'b01, 1'b1, 4'd0, 1'b0, ALU_ADD,  1'b0, 5'd0, 64'd0,  ALU_ADD};
    vecs[6]  = '{32'h008000EF, 32'h00500093, 64'h1000, 2'b11, 2'b01, 1'b0, 4'd0, 1'b1, ALU_JAL,  1'b1, 5'd1, 64'd8,  ALU_ADD};
    vecs[7]  = '{32'h002081B3, 32'h40208233, 64'h1000, 2'b11, 2'b11, 1'b0, 4'd0, 1'b1, ALU_ADD,  1'b0, 5'd3, 64'd0,  ALU_SUB};
    vecs[8]  = '{32'h002081B3, 32'h0020B2B3, 64'h1000, 2'b10, 2'b10, 1'b0, 4'd0, 1'b1, ALU_ADD,  1'b0, 5'd3, 64'd0,  ALU_SLTU};
    vecs[9]  = '{32'h022081B3, 32'h00000013, 64'h1000, 2'b01, 2'b01, 1'b1, 4'd2, 1'b0, ALU_ADD,  1'b0, 5'd0, 64'd0,  ALU_ADD};
    vecs[10] = '{32'h0200909B, 32'h00000013, 64'h1000, 2'b01, 2'b01, 1'b1, 4'd2, 1'b0, ALU_ADD,  1'b0, 5'd0, 64'd0,  ALU_ADD};
    vecs[11] = '{32'h12345137, 32'h00000013, 64'h1000, 2'b01, 2'b01, 1'b0, 4'd0, 1'b1, ALU_ADD,  1'b1, 5'd2, 64'h12345000, ALU_ADD};
    vecs[12] = '{32'hFFF00093, 32'h00000013, 64'h1000, 2'b01, 2'b01, 1'b0, 4'd0, 1'b1, ALU_ADD,  1'b1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, ALU_ADD};

    rstn = 1'b0; flush = 1'b0; valid = 1'b0; ready_in = 1'b0;
    set_bundle(32'h0, 32'h0, 64'h0, 2'b00);
    cnt_exp = '0;
    #1;
    chk("rst_valid", 64'(vout), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_mask", 64'(mask_out), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_instr_zero", 64'(instr == '0), 64'd1);
    chk("rst_wrap_instr_zero", 64'(instr_w == '0), 64'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    for (int k = 0; k < 13; k++) begin
      set_bundle(vecs[k].i0, vecs[k].i1, vecs[k].pc0, vecs[k].mi);
      valid    = 1'b1;
      ready_in = 1'b1;
      tick();
      valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_valid", k), 64'(vout), 64'd1);
      chk($sformatf("v%0d_cnt", k), 64'(cnt), 64'(cnt_exp));
      chk($sformatf("v%0d_mask", k), 64'(mask_out), 64'(vecs[k].mo));
      chk($sformatf("v%0d_ex0", k), 64'(instr[0].ex.valid), 64'(vecs[k].ex0));
      if (vecs[k].ex0) chk($sformatf("v%0d_cause0", k), 64'(instr[0].ex.cause), 64'(vecs[k].cause0));
      if (vecs[k].chk) begin
        chk($sformatf("v%0d_alu0", k), 64'(instr[0].alu_op), 64'(vecs[k].alu0));
        chk($sformatf("v%0d_imm0", k), 64'(instr[0].use_imm), 64'(vecs[k].imm0));
        chk($sformatf("v%0d_rd0", k), 64'(instr[0].rd), 64'(vecs[k].rd0));
        chk($sformatf("v%0d_res0", k), instr[0].result, vecs[k].res0);
      end
      if (vecs[k].mo[1]) chk($sformatf("v%0d_alu1", k), 64'(instr[1].alu_op), 64'(vecs[k].alu1));
      tick();
      cnt_exp = cnt_exp + pop2(vecs[k].mo);
    end
    @(negedge clk);
    chk("vec_cnt_final", 64'(cnt), 64'(cnt_exp));
    tick();

    // backpressure: three bundles against a two-entry buffer
    ready_in = 1'b0;
    set_bundle(32'h00100093, 32'h0, 64'h2000, 2'b01); valid = 1'b1;
    @(negedge clk); chk("bp_ready0", 64'(ready), 64'd1);
    tick();
    set_bundle(32'h00200113, 32'h0, 64'h2010, 2'b01);
    @(negedge clk); chk("bp_head1_rd", 64'(instr[0].rd), 64'd1); chk("bp_ready1", 64'(ready), 64'd1);
    tick();
    set_bundle(32'h00300193, 32'h0, 64'h2020, 2'b01);
    @(negedge clk); chk("bp_full", 64'(ready), 64'd0); chk("bp_hold_rd", 64'(instr[0].rd), 64'd1);
    tick();
    @(negedge clk); chk("bp_full2", 64'(ready), 64'd0); chk("bp_hold_res", instr[0].result, 64'd1);
    tick();
    ready_in = 1'b1;
    @(negedge clk); chk("bp_drain_b1", 64'(instr[0].rd), 64'd1); chk("bp_drain_v", 64'(vout), 64'd1);
    tick();
    @(negedge clk); chk("bp_drain_b2", 64'(instr[0].rd), 64'd2); chk("bp_ready_after_pop", 64'(ready), 64'd1);
    tick();
    valid = 1'b0;
    @(negedge clk); chk("bp_drain_b3", 64'(instr[0].rd), 64'd3); chk("bp_b3_res", instr[0].result, 64'd3);
    tick();
    cnt_exp = cnt_exp + 32'd3;
    @(negedge clk); chk("bp_empty", 64'(vout), 64'd0); chk("bp_cnt", 64'(cnt), 64'(cnt_exp));
    tick();

    // all-zero lane mask: accepted but never buffered
    set_bundle(32'h00500093, 32'h00500093, 64'h3000, 2'b00); valid = 1'b1;
    @(negedge clk); chk("drop_ready", 64'(ready), 64'd1);
    tick();
    valid = 1'b0;
    @(negedge clk); chk("drop_valid", 64'(vout), 64'd0);
    tick();

    // flush with a full buffer and a bundle on the input
    ready_in = 1'b0;
    set_bundle(32'h002081B3, 32'h40208233, 64'h4000, 2'b11); valid = 1'b1;
    tick(); tick();
    @(negedge clk); chk("fl_pre_full", 64'(ready), 64'd0); chk("fl_pre_valid", 64'(vout), 64'd1);
    flush = 1'b1; ready_in = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("fl_valid", 64'(vout), 64'd0);
    chk("fl_ready", 64'(ready), 64'd1);
    chk("fl_cnt", 64'(cnt), 64'(cnt_exp));
    tick();
    // flush also blocks a push into an empty buffer
    valid = 1'b1; flush = 1'b1;
    tick();
    valid = 1'b0; flush = 1'b0;
    @(negedge clk); chk("fl_push_blocked", 64'(vout), 64'd0);
    tick();

    // asynchronous reset with one bundle buffered
    ready_in = 1'b0;
    set_bundle(32'h00500093, 32'h0, 64'h5000, 2'b01); valid = 1'b1;
    tick();
    valid = 1'b0;
    @(negedge clk); chk("rm_pre_valid", 64'(vout), 64'd1);
    #1 rstn = 1'b0;
    #1;
    chk("rm_valid", 64'(vout), 64'd0);
    chk("rm_ready", 64'(ready), 64'd1);
    chk("rm_mask", 64'(mask_out), 64'd0);
    chk("rm_cnt", 64'(cnt), 64'd0);
    chk("rm_wrap_valid", 64'(vout_w), 64'd0);
    chk("rm_wrap_ready", 64'(ready_w), 64'd1);
    cnt_exp = '0;
    tick();
    rstn = 1'b1;
    ready_in = 1'b1;
    @(negedge clk); chk("rm_post_valid", 64'(vout), 64'd0);
    tick();

    // counter wrap on the CNT_W=2 instance: 2 + 1 + 2 lanes
    push_pop(32'h002081B3, 32'h40208233, 2'b11);
    push_pop(32'h00500093, 32'h0, 2'b01);
    @(negedge clk); chk("wrap_pre", 64'(cnt_w), 64'd3); chk("wrap_main_pre", 64'(cnt), 64'(cnt_exp));
    tick();
    set_bundle(32'h002081B3, 32'h40208233, 64'h1000, 2'b11); valid = 1'b1;
    tick();
    valid = 1'b0;
    @(negedge clk); chk("wrap_mask", 64'(mask_w), 64'd3);
    tick();
    cnt_exp = cnt_exp + 32'd2;
    @(negedge clk);
    chk("wrap_cnt", 64'(cnt_w), 64'd1);
    chk("wrap_main_cnt", 64'(cnt), 64'(cnt_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
